// File: rtl/ps2_rx_buffer.sv
// PS/2 device-to-host receiver with scan-code FIFO.
// Optional PS2_BREAK_FILTER_EN drops F0-prefixed break codes.
module ps2_rx_buffer #(
  parameter int FIFO_DEPTH     = 8,
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        ps2_clk_in,
  input  logic                        ps2_data_in,
  input  logic                        key_ack,
  output logic                        ps2_key_pressed,
  output logic [7:0]                  ps2_out,
  output logic                        frame_error,
  output logic                        overflow,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    IDLE, DATA, PARITY, STOP
  } state_t;

  state_t state, state_n;

  logic          clk_s1, clk_s2;
  logic          dat_s1, dat_s2;
  logic          filt, filt_d;
  logic [FW-1:0] flt_cnt;
  logic          fall;

  logic [2:0]    bitcnt;
  logic [7:0]    shreg;
  logic          par;
  logic [TW-1:0] tcnt;
  logic          tout;
  logic          good, bad;
  logic          push;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0]   count;
  logic          full, do_pop, wr;

  // two-flop synchronizers on both pins
  always_ff @(posedge clock) begin
    if (reset) begin
      clk_s1 <= 1'b1;
      clk_s2 <= 1'b1;
      dat_s1 <= 1'b1;
      dat_s2 <= 1'b1;
    end else begin
      clk_s1 <= ps2_clk_in;
      clk_s2 <= clk_s1;
      dat_s1 <= ps2_data_in;
      dat_s2 <= dat_s1;
    end
  end

  // glitch filter: flip only after FILTER_LEN differing samples
  always_ff @(posedge clock) begin
    if (reset) begin
      filt    <= 1'b1;
      filt_d  <= 1'b1;
      flt_cnt <= '0;
    end else begin
      filt_d <= filt;
      if (clk_s2 != filt) begin
        if (flt_cnt == FW'(FILTER_LEN - 1)) begin
          filt    <= clk_s2;
          flt_cnt <= '0;
        end else begin
          flt_cnt <= flt_cnt + FW'(1);
        end
      end else begin
        flt_cnt <= '0;
      end
    end
  end

  assign fall = filt_d & ~filt;
  assign tout = (state != IDLE) && !fall &&
                (tcnt == TW'(TIMEOUT_CYCLES - 1));

  // frame state register
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // next state and frame verdict
  always_comb begin
    state_n = state;
    good    = 1'b0;
    bad     = 1'b0;
    if (tout) begin
      state_n = IDLE;
      bad     = 1'b1;
    end else if (fall) begin
      unique case (state)
        IDLE:   if (!dat_s2) state_n = DATA;
        DATA:   if (bitcnt == 3'd7) state_n = PARITY;
        PARITY: state_n = STOP;
        STOP: begin
          state_n = IDLE;
          if (dat_s2 && (^{shreg, par})) good = 1'b1;
          else                           bad  = 1'b1;
        end
      endcase
    end
  end

  // bit capture, timeout counter and error pulse
  always_ff @(posedge clock) begin
    if (reset) begin
      bitcnt      <= '0;
      shreg       <= '0;
      par         <= 1'b0;
      tcnt        <= '0;
      frame_error <= 1'b0;
    end else begin
      frame_error <= bad;
      if (state == IDLE || fall || tout) tcnt <= '0;
      else                               tcnt <= tcnt + TW'(1);
      if (fall) begin
        unique case (state)
          IDLE:   bitcnt <= '0;
          DATA: begin
            shreg[bitcnt] <= dat_s2;
            bitcnt        <= bitcnt + 3'd1;
          end
          PARITY: par <= dat_s2;
          STOP:   ;
        endcase
      end
    end
  end

`ifdef PS2_BREAK_FILTER_EN
  logic brk;

  assign push = good && !brk && (shreg != 8'hF0);

  // break prefix swallows itself and the following code
  always_ff @(posedge clock) begin
    if (reset)     brk <= 1'b0;
    else if (bad)  brk <= 1'b0;
    else if (good) brk <= brk ? 1'b0 : (shreg == 8'hF0);
  end
`else
  assign push = good;
`endif

  assign full   = (count == (AW + 1)'(FIFO_DEPTH));
  assign do_pop = key_ack && (count != '0);
  assign wr     = push && (!full || do_pop);

  // FIFO storage
  always_ff @(posedge clock) begin
    if (wr) mem[wp] <= shreg;
  end

  // FIFO pointers, occupancy and sticky overflow
  always_ff @(posedge clock) begin
    if (reset) begin
      wp       <= '0;
      rp       <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr)     wp <= wp + AW'(1);
      if (do_pop) rp <= rp + AW'(1);
      if (wr && !do_pop)      count <= count + (AW + 1)'(1);
      else if (!wr && do_pop) count <= count - (AW + 1)'(1);
      if (push && full && !do_pop) overflow <= 1'b1;
    end
  end

  assign fifo_count      = count;
  assign ps2_key_pressed = (count != '0);
  assign ps2_out         = ps2_key_pressed ? mem[rp] : 8'h00;

endmodule

// File: tb/tb_ps2_rx_buffer.sv
// Directed bench for ps2_rx_buffer.
// Frames are bit-banged on the pins; expectations are hand-computed.
module tb_ps2_rx_buffer;

  localparam int TMO = 300;

  logic       clock;
  logic       reset;
  logic       ps2_clk_in;
  logic       ps2_data_in;
  logic       key_ack;
  logic       ps2_key_pressed;
  logic [7:0] ps2_out;
  logic       frame_error;
  logic       overflow;
  logic [3:0] fifo_count;

  int checks;
  int failures;
  int ferr_cnt;
  int f0;

  ps2_rx_buffer #(
    .FIFO_DEPTH    (8),
    .FILTER_LEN    (4),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .ps2_clk_in     (ps2_clk_in),
    .ps2_data_in    (ps2_data_in),
    .key_ack        (key_ack),
    .ps2_key_pressed(ps2_key_pressed),
    .ps2_out        (ps2_out),
    .frame_error    (frame_error),
    .overflow       (overflow),
    .fifo_count     (fifo_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // count cycles with frame_error high
  always @(negedge clock) begin
    if (frame_error === 1'b1) ferr_cnt++;
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  // one PS/2 bit; optional ack lands on the push edge
  task automatic send_bit(input logic b, input logic ack_sync);
    ps2_data_in = b;
    cyc(5);
    ps2_clk_in = 1'b0;
    cyc(6);
    if (ack_sync) key_ack = 1'b1;
    cyc(1);
    key_ack = 1'b0;
    cyc(3);
    ps2_clk_in = 1'b1;
    cyc(5);
  endtask

  task automatic send_frame(input logic [7:0] b,
                            input logic bad_par,
                            input logic stop,
                            input logic ack_last);
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i], 1'b0);
    send_bit((~^b) ^ bad_par, 1'b0);
    send_bit(stop, ack_last);
    ps2_data_in = 1'b1;
  endtask

  task automatic ack1;
    key_ack = 1'b1;
    cyc(1);
    key_ack = 1'b0;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
  endtask

  logic [7:0] exp_q [$];

  initial begin
    checks      = 0;
    failures    = 0;
    ferr_cnt    = 0;
    reset       = 1'b1;
    ps2_clk_in  = 1'b1;
    ps2_data_in = 1'b1;
    key_ack     = 1'b0;
    cyc(3);
    reset = 1'b0;
    cyc(1);
    check("rst_pressed", ps2_key_pressed, 0);
    check("rst_out", ps2_out, 0);
    check("rst_count", fifo_count, 0);
    check("rst_ovf", overflow, 0);
    check("rst_ferr", ferr_cnt, 0);

    // valid frame and pop
    send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
    check("v_pressed", ps2_key_pressed, 1);
    check("v_out", ps2_out, 8'h1C);
    check("v_count", fifo_count, 1);
    ack1();
    check("v_pop_pressed", ps2_key_pressed, 0);
    check("v_pop_out", ps2_out, 0);
    check("v_pop_count", fifo_count, 0);
    ack1();
    check("ack_empty", fifo_count, 0);

    // parity error, then good frame
    f0 = ferr_cnt;
    send_frame(8'h1C, 1'b1, 1'b1, 1'b0);
    cyc(2);
    check("par_ferr", ferr_cnt - f0, 1);
    check("par_count", fifo_count, 0);
    send_frame(8'h32, 1'b0, 1'b1, 1'b0);
    check("par_next_out", ps2_out, 8'h32);
    check("par_next_cnt", fifo_count, 1);
    ack1();

    // stop-bit error
    f0 = ferr_cnt;
    send_frame(8'h5A, 1'b0, 1'b0, 1'b0);
    cyc(2);
    check("stop_ferr", ferr_cnt - f0, 1);
    check("stop_count", fifo_count, 0);

    // overflow
    for (int i = 1; i <= 9; i++)
      send_frame(8'(i), 1'b0, 1'b1, 1'b0);
    check("ovf_count", fifo_count, 8);
    check("ovf_flag", overflow, 1);
    check("ovf_head", ps2_out, 8'h01);
    for (int i = 1; i <= 8; i++) begin
      check("ovf_drain", ps2_out, 32'(i));
      ack1();
    end
    check("ovf_empty", fifo_count, 0);
    check("ovf_sticky", overflow, 1);
    do_reset();
    check("ovf_rst", overflow, 0);

    // glitch with data low must not start a frame
    f0 = ferr_cnt;
    ps2_data_in = 1'b0;
    cyc(2);
    ps2_clk_in = 1'b0;
    cyc(2);
    ps2_clk_in = 1'b1;
    cyc(10);
    ps2_data_in = 1'b1;
    cyc(10);
    send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
    check("glitch_out", ps2_out, 8'h1C);
    check("glitch_cnt", fifo_count, 1);
    check("glitch_ferr", ferr_cnt - f0, 0);
    ack1();

    // timeout on a partial frame
    f0 = ferr_cnt;
    send_bit(1'b0, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b0, 1'b1 & 1'b0);
    send_bit(1'b1, 1'b0);
    ps2_data_in = 1'b1;
    cyc(TMO + 100);
    check("tmo_ferr", ferr_cnt - f0, 1);
    check("tmo_count", fifo_count, 0);
    send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
    check("tmo_next_out", ps2_out, 8'h1C);
    check("tmo_next_cnt", fifo_count, 1);
    do_reset();

    // push and pop together while full
    for (int i = 1; i <= 8; i++)
      send_frame(8'(i), 1'b0, 1'b1, 1'b0);
    send_frame(8'h09, 1'b0, 1'b1, 1'b1);
    check("sim_full_cnt", fifo_count, 8);
    check("sim_full_ovf", overflow, 0);
    check("sim_full_head", ps2_out, 8'h02);
    do_reset();

    // push and pop together while empty
    send_frame(8'h1C, 1'b0, 1'b1, 1'b1);
    check("sim_empty_cnt", fifo_count, 1);
    check("sim_empty_out", ps2_out, 8'h1C);
    check("sim_empty_ovf", overflow, 0);

    // reset in the middle of a frame
    f0 = ferr_cnt;
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    ps2_data_in = 1'b1;
    do_reset();
    check("mid_rst_cnt", fifo_count, 0);
    check("mid_rst_out", ps2_out, 0);
    cyc(TMO + 100);
    check("mid_rst_ferr", ferr_cnt - f0, 0);
    send_frame(8'h32, 1'b0, 1'b1, 1'b0);
    check("mid_rst_next", ps2_out, 8'h32);
    check("mid_rst_ncnt", fifo_count, 1);
    do_reset();

    // break-code handling
    send_frame(8'hF0, 1'b0, 1'b1, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
    send_frame(8'hE0, 1'b0, 1'b1, 1'b0);
    send_frame(8'h75, 1'b0, 1'b1, 1'b0);
`ifdef PS2_BREAK_FILTER_EN
    exp_q = '{8'hE0, 8'h75};
`else
    exp_q = '{8'hF0, 8'h1C, 8'hE0, 8'h75};
`endif
    check("brk_cnt", fifo_count, 32'(exp_q.size()));
    foreach (exp_q[i]) begin
      check("brk_seq", ps2_out, 32'(exp_q[i]));
      ack1();
    end
    check("brk_empty", fifo_count, 0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
